// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus from the core plus the UART-side RX/TX byte streams.
// Streams use valid/ready: a byte moves on every clock edge where valid && ready are both high.
interface mem_io_responder_if;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output bus_a, bus_wr, bus_wdata, rx_valid, rx_data, tx_ready,
    input  bus_rdata, rx_ready, tx_valid, tx_data
  );

  modport slave (
    input  bus_a, bus_wr, bus_wdata, rx_valid, rx_data, tx_ready,
    output bus_rdata, rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/mem_io_responder.sv
// Target end of the core's byte bus: RAM plus an I/O window at 0x30000 with
// RX/TX byte queues, a free-running cycle counter and a sticky program-stop flag.
module mem_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TXQ_DEPTH   = 8,
  parameter int RXQ_DEPTH   = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  mem_io_responder_if.slave bus,
  output logic              io_buffer_full,
  output logic              prog_stop,
  output logic              tx_overflow
);
  localparam int TXP = $clog2(TXQ_DEPTH);
  localparam int RXP = $clog2(RXQ_DEPTH);
  localparam logic [TXP:0] TX_DEPTH_C = (TXP+1)'(TXQ_DEPTH);
  localparam logic [RXP:0] RX_DEPTH_C = (RXP+1)'(RXQ_DEPTH);
  localparam logic [TXP:0] FULL_C     = (TXP+1)'(FULL_MARGIN);

  logic [7:0] ram_q    [2**ADDR_WIDTH];
  logic [7:0] tx_mem_q [TXQ_DEPTH];
  logic [7:0] rx_mem_q [RXQ_DEPTH];

  logic [TXP-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TXP:0]   tx_cnt_q, tx_cnt_d;
  logic [RXP-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RXP:0]   rx_cnt_q, rx_cnt_d;
  logic [31:0]    cyc_q, cyc_d, snap_q, snap_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           stop_q, stop_d, ovf_q, ovf_d;

  logic                  io_sel;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [15:0]           io_off;
  logic                  bus_rd, ram_wr, stop_wr, tx_req, tx_full, tx_pop, tx_push;
  logic                  rx_empty, rx_pop, rx_push;
  logic [7:0]            tx_byte;
  logic                  unused_addr;

  assign io_sel      = (bus.bus_a[17:16] == 2'b11);
  assign ram_idx     = bus.bus_a[ADDR_WIDTH-1:0];
  assign io_off      = bus.bus_a[15:0];
  assign unused_addr = ^bus.bus_a[31:18];

  assign bus_rd  = rdy_in && !bus.bus_wr;
  assign ram_wr  = rdy_in && bus.bus_wr && !io_sel;
  assign stop_wr = rdy_in && bus.bus_wr && io_sel && (io_off == 16'h0004);
  // A zero byte written to the data port is a no-op; the stop port always queues a 0x00 terminator.
  assign tx_req  = stop_wr ||
                   (rdy_in && bus.bus_wr && io_sel && (io_off == 16'h0000) && (bus.bus_wdata != 8'h00));
  assign tx_byte = stop_wr ? 8'h00 : bus.bus_wdata;

  assign tx_full  = (tx_cnt_q == TX_DEPTH_C);
  assign tx_pop   = (tx_cnt_q != '0) && bus.tx_ready;
  assign tx_push  = tx_req && (!tx_full || tx_pop);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = bus_rd && io_sel && (io_off == 16'h0000) && !rx_empty;
  assign rx_push  = bus.rx_valid && (rx_cnt_q != RX_DEPTH_C);

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_comb begin
    cyc_d   = rdy_in ? cyc_q + 32'd1 : cyc_q;
    stop_d  = stop_q | stop_wr;
    ovf_d   = ovf_q | (tx_req && !tx_push);
    snap_d  = snap_q;
    rdata_d = rdata_q;
    if (bus_rd) begin
      if (!io_sel) begin
        rdata_d = ram_q[ram_idx];
      end else begin
        // The 0x30004 read latches the whole counter so 0x30005..7 return a coherent word.
        case (io_off)
          16'h0000: rdata_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
          16'h0004: begin
            rdata_d = cyc_q[7:0];
            snap_d  = cyc_q;
          end
          16'h0005: rdata_d = snap_q[15:8];
          16'h0006: rdata_d = snap_q[23:16];
          16'h0007: rdata_d = snap_q[31:24];
          default:  rdata_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      cyc_q       <= '0;
      snap_q      <= '0;
      rdata_q     <= '0;
      stop_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      cyc_q       <= cyc_d;
      snap_q      <= snap_d;
      rdata_q     <= rdata_d;
      stop_q      <= stop_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage arrays carry no reset; the pointers and counts define what is valid.
  always_ff @(posedge clk_in) begin
    if (ram_wr)  ram_q[ram_idx]         <= bus.bus_wdata;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_byte;
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.rx_data;
  end

  assign bus.bus_rdata  = rdata_q;
  assign bus.tx_valid   = (tx_cnt_q != '0);
  assign bus.tx_data    = tx_mem_q[tx_rd_ptr_q];
  assign bus.rx_ready   = (rx_cnt_q != RX_DEPTH_C);
  assign io_buffer_full = ((TX_DEPTH_C - tx_cnt_q) <= FULL_C);
  assign prog_stop      = stop_q;
  assign tx_overflow    = ovf_q;
endmodule
